// File: rtl/nes_bus_responder.sv
// CPU-bus target for the nes6502 core: work RAM, joypad serial ports, PPU register
// pass-through and synchronous PRG ROM pass-through, with single-shot access detection.
module nes_bus_responder #(
  parameter int          RAM_AW   = 11,
  parameter int          ROM_AW   = 15,
  parameter logic [7:0]  OPEN_BUS = 8'h40
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       address,
  input  logic [7:0]        out,
  input  logic              rd,
  input  logic              we,
  output logic [7:0]        din,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [7:0]        rom_data,
  output logic [2:0]        ppu_address,
  output logic [7:0]        ppu_wdata,
  output logic              ppu_we,
  output logic              ppu_rd,
  input  logic [7:0]        ppu_rdata,
  input  logic [7:0]        joy1,
  input  logic [7:0]        joy2
);

  typedef enum logic [1:0] {SRC_REG, SRC_RAM, SRC_ROM} src_e;

  logic [7:0]  din_q, din_d;
  src_e        src_q, src_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  sr1_q, sr1_d;
  logic [7:0]  sr2_q, sr2_d;
  logic        prev_act_q;
  logic [15:0] prev_addr_q;
  logic [7:0]  ram_q;
  logic [7:0]  ram_mem [0:(1<<RAM_AW)-1];

  logic sel_ram, sel_ppu, sel_joy1, sel_joy2, sel_rom;
  logic start, rd_start, wr_start;

  assign sel_ram  = (address[15:13] == 3'b000);
  assign sel_ppu  = (address[15:13] == 3'b001);
  assign sel_joy1 = (address == 16'h4016);
  assign sel_joy2 = (address == 16'h4017);
  assign sel_rom  = address[15];

  // A held request on an unchanged address is one access; only its first cycle acts.
  assign start    = (rd | we) & (~prev_act_q | (address != prev_addr_q));
  assign wr_start = start & we;
  assign rd_start = start & rd & ~we;

  assign rom_address = address[ROM_AW-1:0];
  assign ppu_address = address[2:0];
  assign ppu_wdata   = out;
  assign ppu_we      = wr_start & sel_ppu & reset_n;
  assign ppu_rd      = rd_start & sel_ppu & reset_n;

  always_comb begin
    case (src_q)
      SRC_RAM: din = ram_q;
      SRC_ROM: din = rom_data;
      default: din = din_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_start && sel_ram && reset_n) begin
      ram_mem[address[RAM_AW-1:0]] <= out;
    end
    ram_q <= ram_mem[address[RAM_AW-1:0]];
  end

  always_comb begin
    // RAM/ROM results live one cycle in the source mux, then fold into din_q.
    din_d    = din;
    src_d    = SRC_REG;
    strobe_d = strobe_q;
    sr1_d    = strobe_q ? joy1 : sr1_q;
    sr2_d    = strobe_q ? joy2 : sr2_q;
    if (wr_start && sel_joy1) begin
      strobe_d = out[0];
    end
    if (rd_start) begin
      if (sel_ram) begin
        src_d = SRC_RAM;
      end else if (sel_rom) begin
        src_d = SRC_ROM;
      end else if (sel_ppu) begin
        din_d = ppu_rdata;
      end else if (sel_joy1) begin
        din_d = OPEN_BUS | {7'b0, (strobe_q ? joy1[0] : sr1_q[0])};
        if (!strobe_q) sr1_d = {1'b1, sr1_q[7:1]};
      end else if (sel_joy2) begin
        din_d = OPEN_BUS | {7'b0, (strobe_q ? joy2[0] : sr2_q[0])};
        if (!strobe_q) sr2_d = {1'b1, sr2_q[7:1]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      din_q       <= 8'h00;
      src_q       <= SRC_REG;
      strobe_q    <= 1'b0;
      sr1_q       <= 8'hFF;
      sr2_q       <= 8'hFF;
      prev_act_q  <= 1'b0;
      prev_addr_q <= 16'h0000;
    end else begin
      din_q       <= din_d;
      src_q       <= src_d;
      strobe_q    <= strobe_d;
      sr1_q       <= sr1_d;
      sr2_q       <= sr2_d;
      prev_act_q  <= rd | we;
      prev_addr_q <= address;
    end
  end

endmodule
